// File: rtl/cpu_multi_cycle.sv
// Multi-cycle MIPS-subset core sharing one req/ready memory port between fetch and load/store.
// Unsupported instructions and misaligned data addresses park the core in TRAP until reset.
module cpu_multi_cycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  input  logic [4:0]        dbg_sel,
  output logic [31:0]       dbg_data,
  output logic [31:0]       debug_pc,
  output logic [31:0]       retired,
  output logic              halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  state_t state, state_nxt;

  logic [31:0]        pc;
  logic [31:0]        ir_p0;
  logic signed [31:0] a_p1, b_p1;
  logic signed [31:0] alu_p2;
  logic [31:0]        mdr_p3;
  logic [31:0]        regs [32];

  logic [5:0]         opcode, funct;
  logic [4:0]         rs, rt, rd;
  logic signed [31:0] imm_sext;
  logic [31:0]        imm_zext;

  logic               legal, is_rtype, is_jump, is_branch, is_load, is_store, is_mem_op;
  logic               take_branch, misaligned, retire;
  logic signed [31:0] alu_res;
  logic [4:0]         wb_dst;
  logic [31:0]        wb_val;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: is_legal = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                           (fn == FN_OR)  || (fn == FN_SLT);
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: is_legal = 1'b1;
      default:  is_legal = 1'b0;
    endcase
  endfunction

  // Arithmetic wraps modulo 2^32; slt compares as two's complement.
  function automatic logic signed [31:0] alu_calc(
    input logic [5:0]         op,
    input logic [5:0]         fn,
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input logic signed [31:0] sx,
    input logic [31:0]        zx
  );
    logic signed [31:0] r;
    r = '0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  r = a + b;
          FN_SUB:  r = a - b;
          FN_AND:  r = a & b;
          FN_OR:   r = a | b;
          FN_SLT:  r = (a < b) ? 32'sd1 : 32'sd0;
          default: r = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: r = a + sx;
      OP_ANDI: r = a & $signed(zx);
      OP_ORI:  r = a | $signed(zx);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic br_taken(input logic [5:0] op, input logic signed [31:0] a,
                                    input logic signed [31:0] b);
    return ((op == OP_BEQ) && (a == b)) || ((op == OP_BNE) && (a != b));
  endfunction

  assign opcode   = ir_p0[31:26];
  assign rs       = ir_p0[25:21];
  assign rt       = ir_p0[20:16];
  assign rd       = ir_p0[15:11];
  assign funct    = ir_p0[5:0];
  assign imm_sext = {{16{ir_p0[15]}}, ir_p0[15:0]};
  assign imm_zext = {16'h0000, ir_p0[15:0]};

  assign legal       = is_legal(opcode, funct);
  assign is_rtype    = (opcode == OP_RTYPE);
  assign is_jump     = (opcode == OP_J);
  assign is_branch   = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_load     = (opcode == OP_LW);
  assign is_store    = (opcode == OP_SW);
  assign is_mem_op   = is_load || is_store;
  assign take_branch = br_taken(opcode, a_p1, b_p1);
  assign alu_res     = alu_calc(opcode, funct, a_p1, b_p1, imm_sext, imm_zext);
  assign misaligned  = (alu_res[1:0] != 2'b00);

  assign wb_dst = is_rtype ? rd : rt;
  assign wb_val = is_load ? mdr_p3 : alu_p2;

  assign mem_wdata = b_p1;
  assign dbg_data  = (dbg_sel == 5'd0) ? 32'h0 : regs[dbg_sel];
  assign debug_pc  = pc;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        if (!legal)       state_nxt = TRAP;
        else if (is_jump) state_nxt = FETCH;
        else              state_nxt = EXEC;
      end
      EXEC: begin
        if (is_branch)      state_nxt = FETCH;
        else if (is_mem_op) state_nxt = misaligned ? TRAP : MEM;
        else                state_nxt = WB;
      end
      MEM:     if (mem_ready) state_nxt = is_store ? FETCH : WB;
      WB:      state_nxt = FETCH;
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  // Requests are masked while reset is high so an abandoned access never completes.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc[ADDR_W-1:0];
    retire   = 1'b0;
    halted   = 1'b0;
    case (state)
      FETCH:  mem_req = !reset;
      DECODE: retire = legal && is_jump;
      EXEC:   retire = is_branch;
      MEM: begin
        mem_req  = !reset;
        mem_we   = is_store && !reset;
        mem_addr = alu_p2[ADDR_W-1:0];
        retire   = is_store && mem_ready;
      end
      WB:     retire = 1'b1;
      TRAP:   halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      retired <= '0;
    end else begin
      if (retire) retired <= retired + 32'd1;
      case (state)
        FETCH:   if (mem_ready) pc <= pc + 32'd4;
        DECODE:  if (legal && is_jump) pc <= {pc[31:28], ir_p0[25:0], 2'b00};
        EXEC:    if (take_branch) pc <= pc + $unsigned(imm_sext <<< 2);
        default: ;
      endcase
    end
  end

  // Stage boundaries: fetch -> ir_p0, decode -> a_p1/b_p1, exec -> alu_p2, mem -> mdr_p3.
  always_ff @(posedge clk) begin
    if (state == FETCH && mem_ready) ir_p0 <= mem_rdata;
    if (state == DECODE) begin
      a_p1 <= regs[rs];
      b_p1 <= regs[rt];
    end
    if (state == EXEC) alu_p2 <= alu_res;
    if (state == MEM && mem_ready) mdr_p3 <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (state == WB && wb_dst != 5'd0) begin
      regs[wb_dst] <= wb_val;
    end
  end

endmodule

// File: tb/tb_cpu_multi_cycle.sv
// Bench for cpu_multi_cycle: word memory with programmable wait states and an ISA-level
// reference interpreter for randomly generated programs.
module tb_cpu_multi_cycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data, debug_pc, retired;
  logic        halted;

  always #5 clk = ~clk;

  cpu_multi_cycle #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .debug_pc(debug_pc),
    .retired(retired), .halted(halted)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] img [1024];
  logic [31:0] mem [1024];
  logic [31:0] rm_reg [32];
  logic [31:0] rm_mem [1024];
  logic        load_req = 1'b0;
  int          wait_states = 0;
  bit          rand_waits = 1'b0;
  int          wcnt = 0;
  int          tgt = 0;
  int          acc_cnt = 0;

  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= img[i];
      acc_cnt <= 0;
    end else if (mem_req && mem_ready) begin
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
      acc_cnt <= acc_cnt + 1;
    end
  end

  // mem_ready is random while idle: the core must ignore it.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt >= tgt) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[mem_addr[11:2]];
        wcnt      <= 0;
        tgt       <= rand_waits ? int'($urandom_range(0, 2)) : wait_states;
      end else begin
        mem_ready <= 1'b0;
        wcnt      <= wcnt + 1;
      end
    end else begin
      mem_ready <= 1'($urandom_range(0, 1));
      mem_rdata <= $urandom;
      wcnt      <= 0;
      tgt       <= rand_waits ? int'($urandom_range(0, 2)) : wait_states;
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = ILLEGAL;
  endtask

  task automatic start(input int ws, input bit rw);
    reset = 1'b1;
    wait_states = ws;
    rand_waits = rw;
    load_req = 1'b1;
    cyc();
    load_req = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic run_halt(input int max_cyc, input string name);
    int c;
    c = 0;
    while (halted !== 1'b1 && c < max_cyc) begin
      cyc();
      c++;
    end
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: halted=%0b after %0d cycles, required 1", name, halted, c);
    end
  endtask

  task automatic wreg(input logic [4:0] d, input logic [31:0] v);
    if (d != 5'd0) rm_reg[d] = v;
  endtask

  // Instruction-level interpreter: runs the image from PC 0 until an illegal op or misaligned access.
  task automatic ref_run(output int ret, output logic [31:0] fpc);
    logic [31:0] pc, ins, a, b, sx, zx, res, ad;
    bit          stop;
    for (int i = 0; i < 1024; i++) rm_mem[i] = img[i];
    for (int r = 0; r < 32; r++) rm_reg[r] = 32'h0;
    pc = 32'h0;
    ret = 0;
    stop = 1'b0;
    for (int s = 0; s < 2000 && !stop; s++) begin
      ins = rm_mem[pc[11:2]];
      pc = pc + 4;
      a = rm_reg[ins[25:21]];
      b = rm_reg[ins[20:16]];
      sx = {{16{ins[15]}}, ins[15:0]};
      zx = {16'h0, ins[15:0]};
      res = 32'h0;
      case (ins[31:26])
        6'h00: begin
          case (ins[5:0])
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: stop = 1'b1;
          endcase
          if (!stop) begin wreg(ins[15:11], res); ret++; end
        end
        6'h08: begin wreg(ins[20:16], a + sx); ret++; end
        6'h0C: begin wreg(ins[20:16], a & zx); ret++; end
        6'h0D: begin wreg(ins[20:16], a | zx); ret++; end
        6'h23: begin
          ad = a + sx;
          if (ad[1:0] != 2'b00) stop = 1'b1;
          else begin wreg(ins[20:16], rm_mem[ad[11:2]]); ret++; end
        end
        6'h2B: begin
          ad = a + sx;
          if (ad[1:0] != 2'b00) stop = 1'b1;
          else begin rm_mem[ad[11:2]] = b; ret++; end
        end
        6'h04: begin if (a == b) pc = pc + (sx << 2); ret++; end
        6'h05: begin if (a != b) pc = pc + (sx << 2); ret++; end
        6'h02: begin pc = {pc[31:28], ins[25:0], 2'b00}; ret++; end
        default: stop = 1'b1;
      endcase
    end
    fpc = pc;
  endtask

  task automatic test_reset();
    clear_img();
    reset = 1'b1;
    load_req = 1'b1;
    cyc();
    load_req = 1'b0;
    cyc();
    n_checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req: req=%0b we=%0b, required 0/0", mem_req, mem_we);
    end
    n_checks++;
    if (retired !== 32'h0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: retired=%0d halted=%0b, required 0/0", retired, halted);
    end
    n_checks++;
    if (debug_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc: pc=%h, required 00000000", debug_pc);
    end
  endtask

  task automatic test_alu_latency();
    clear_img();
    img[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd5);
    img[1] = enc_i(6'h08, 5'd0, 5'd4, 16'd7);
    img[2] = enc_r(5'd3, 5'd4, 5'd3, 6'h20);
    start(0, 1'b0);
    for (int i = 0; i < 12; i++) cyc();
    n_checks++;
    if (retired !== 32'd3) begin
      n_fail++;
      $display("FAIL alu_retired: got %0d, required 3", retired);
    end
    n_checks++;
    if (debug_pc !== 32'd12) begin
      n_fail++;
      $display("FAIL alu_pc: got %0d, required 12", debug_pc);
    end
    dbg_sel = 5'd3;
    #1;
    n_checks++;
    if (dbg_data !== 32'd12) begin
      n_fail++;
      $display("FAIL alu_reg3: got %0d, required 12", dbg_data);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] pa, pd, pret;
    logic        pw, preq;
    int          c2, c3;
    clear_img();
    img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0040);
    img[1] = enc_i(6'h2B, 5'd1, 5'd1, 16'h0000);
    img[2] = enc_i(6'h23, 5'd1, 5'd2, 16'h0000);
    img[16] = 32'h1234_5678;
    start(3, 1'b0);
    c2 = -1;
    c3 = -1;
    for (int c = 0; c < 300 && halted !== 1'b1; c++) begin
      pa = mem_addr; pw = mem_we; pd = mem_wdata; preq = mem_req; pret = retired;
      cyc();
      if (preq && !mem_ready) begin
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== pa || mem_we !== pw || (pw && mem_wdata !== pd)) begin
          n_fail++;
          $display("FAIL stall_stable: req=%0b addr=%h we=%0b wdata=%h, required 1 %h %0b %h",
                   mem_req, mem_addr, mem_we, mem_wdata, pa, pw, pd);
        end
      end
      if (retired == 32'd2 && pret == 32'd1) c2 = c;
      if (retired == 32'd3 && pret == 32'd2) c3 = c;
    end
    n_checks++;
    if (c2 < 0 || c3 - c2 != 11) begin
      n_fail++;
      $display("FAIL lw_latency: got %0d cycles, required 11", c3 - c2);
    end
    n_checks++;
    if (mem[16] !== 32'h40) begin
      n_fail++;
      $display("FAIL sw_data: mem[0x40]=%h, required 00000040", mem[16]);
    end
    dbg_sel = 5'd2;
    #1;
    n_checks++;
    if (dbg_data !== 32'h40) begin
      n_fail++;
      $display("FAIL lw_reg2: got %h, required 00000040", dbg_data);
    end
  endtask

  task automatic test_loop();
    clear_img();
    img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
    img[1] = enc_i(6'h08, 5'd1, 5'd1, 16'hFFFF);
    img[2] = enc_i(6'h05, 5'd1, 5'd0, 16'hFFFE);
    start(0, 1'b1);
    run_halt(400, "loop");
    n_checks++;
    if (retired !== 32'd7) begin
      n_fail++;
      $display("FAIL loop_retired: got %0d, required 7", retired);
    end
    n_checks++;
    if (debug_pc !== 32'd16) begin
      n_fail++;
      $display("FAIL loop_pc: got %0d, required 16", debug_pc);
    end
    dbg_sel = 5'd1;
    #1;
    n_checks++;
    if (dbg_data !== 32'd0) begin
      n_fail++;
      $display("FAIL loop_reg1: got %0d, required 0", dbg_data);
    end
  endtask

  task automatic test_trap();
    bit req_seen;
    clear_img();
    img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    img[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
    img[2] = 32'hFC00_0000;
    start(0, 1'b0);
    for (int i = 0; i < 10; i++) cyc();
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL trap_halted: got %0b, required 1", halted);
    end
    req_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req !== 1'b0) req_seen = 1'b1;
      cyc();
    end
    n_checks++;
    if (req_seen) begin
      n_fail++;
      $display("FAIL trap_no_req: mem_req seen high while halted, required 0");
    end
    n_checks++;
    if (retired !== 32'd2 || debug_pc !== 32'd12) begin
      n_fail++;
      $display("FAIL trap_state: retired=%0d pc=%0d, required 2/12", retired, debug_pc);
    end
    reset = 1'b1;
    cyc();
    n_checks++;
    if (halted !== 1'b0 || debug_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL trap_reset: halted=%0b pc=%h, required 0/00000000", halted, debug_pc);
    end
  endtask

  task automatic test_misaligned();
    clear_img();
    img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0041);
    img[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd77);
    img[2] = enc_i(6'h23, 5'd1, 5'd2, 16'h0000);
    img[16] = 32'hAAAA_5555;
    start(0, 1'b0);
    run_halt(100, "misaligned");
    n_checks++;
    if (acc_cnt !== 3) begin
      n_fail++;
      $display("FAIL misaligned_access: %0d accesses, required 3", acc_cnt);
    end
    n_checks++;
    if (retired !== 32'd2 || debug_pc !== 32'd12) begin
      n_fail++;
      $display("FAIL misaligned_state: retired=%0d pc=%0d, required 2/12", retired, debug_pc);
    end
    dbg_sel = 5'd2;
    #1;
    n_checks++;
    if (dbg_data !== 32'd77) begin
      n_fail++;
      $display("FAIL misaligned_reg2: got %0d, required 77", dbg_data);
    end
  endtask

  task automatic test_reset_mid_store();
    int c;
    clear_img();
    img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0040);
    img[1] = enc_i(6'h08, 5'd0, 5'd2, 16'h0055);
    img[2] = enc_i(6'h2B, 5'd1, 5'd2, 16'h0000);
    img[16] = 32'hDEAD_BEEF;
    start(5, 1'b0);
    c = 0;
    while (!(mem_req === 1'b1 && mem_we === 1'b1) && c < 300) begin
      cyc();
      c++;
    end
    n_checks++;
    if (mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL midstore_reach: store request not seen after %0d cycles", c);
    end
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL midstore_req: got %0b, required 0", mem_req);
    end
    cyc();
    n_checks++;
    if (mem[16] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL midstore_mem: mem[0x40]=%h, required deadbeef", mem[16]);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL midstore_refetch: req=%0b addr=%h, required 1/00000000", mem_req, mem_addr);
    end
  endtask

  task automatic test_zero_reg();
    clear_img();
    img[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    img[1] = enc_i(6'h08, 5'd0, 5'd5, 16'd9);
    start(0, 1'b0);
    for (int i = 0; i < 8; i++) cyc();
    n_checks++;
    if (retired !== 32'd2) begin
      n_fail++;
      $display("FAIL zero_retired: got %0d, required 2", retired);
    end
    dbg_sel = 5'd0;
    #1;
    n_checks++;
    if (dbg_data !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_reg0: got %0d, required 0", dbg_data);
    end
    dbg_sel = 5'd5;
    #1;
    n_checks++;
    if (dbg_data !== 32'd9) begin
      n_fail++;
      $display("FAIL zero_reg5: got %0d, required 9", dbg_data);
    end
  endtask

  task automatic gen_prog(input int n);
    logic [5:0]  fns [5];
    logic [4:0]  s, t, d;
    logic [15:0] imm;
    int          k;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    clear_img();
    for (int i = 512; i < 528; i++) img[i] = $urandom;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      s = 5'($urandom_range(0, 7));
      t = 5'($urandom_range(0, 7));
      d = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      case (k)
        0, 1, 2: img[i] = enc_r(s, t, d, fns[$urandom_range(0, 4)]);
        3:       img[i] = enc_i(6'h08, s, t, imm);
        4:       img[i] = enc_i(6'h0C, s, t, imm);
        5:       img[i] = enc_i(6'h0D, s, t, imm);
        6:       img[i] = enc_i(6'h2B, 5'd0, t, 16'h0800 + 16'(4 * $urandom_range(0, 15)));
        7:       img[i] = enc_i(6'h23, 5'd0, t, 16'h0800 + 16'(4 * $urandom_range(0, 15)));
        8:       img[i] = enc_i($urandom_range(0, 1) ? 6'h04 : 6'h05, s, t,
                                16'($urandom_range(0, 2)));
        default: img[i] = enc_i(6'h08, s, t, 16'hFF00 | 16'($urandom_range(0, 255)));
      endcase
    end
  endtask

  task automatic test_random();
    int          exp_ret;
    logic [31:0] exp_pc;
    for (int it = 0; it < 3; it++) begin
      gen_prog(24);
      ref_run(exp_ret, exp_pc);
      start(0, 1'b1);
      run_halt(3000, "random");
      n_checks++;
      if (retired !== 32'(exp_ret) || debug_pc !== exp_pc) begin
        n_fail++;
        $display("FAIL random_state it%0d: retired=%0d pc=%h, required %0d/%h",
                 it, retired, debug_pc, exp_ret, exp_pc);
      end
      for (int r = 1; r < 32; r++) begin
        dbg_sel = 5'(r);
        #1;
        n_checks++;
        if (dbg_data !== rm_reg[r]) begin
          n_fail++;
          $display("FAIL random_reg it%0d r%0d: got %h, required %h", it, r, dbg_data, rm_reg[r]);
        end
      end
      for (int w = 512; w < 528; w++) begin
        n_checks++;
        if (mem[w] !== rm_mem[w]) begin
          n_fail++;
          $display("FAIL random_mem it%0d [%h]: got %h, required %h", it, w * 4, mem[w], rm_mem[w]);
        end
      end
    end
    reset = 1'b1;
    cyc();
    for (int r = 1; r < 32; r++) begin
      dbg_sel = 5'(r);
      #1;
      n_checks++;
      if (dbg_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_clears r%0d: got %h, required 0", r, dbg_data);
      end
    end
    n_checks++;
    if (retired !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_retired: got %0d, required 0", retired);
    end
  endtask

  initial begin
    reset = 1'b1;
    dbg_sel = 5'd0;
    test_reset();
    test_alu_latency();
    test_wait_states();
    test_loop();
    test_trap();
    test_misaligned();
    test_reset_mid_store();
    test_zero_reg();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_multi_cycle.md
Name: cpu_multi_cycle

Overview:
- Next-generation MIPS-subset core: multi-cycle FSM datapath with a single unified memory port under a req/ready handshake, so instruction and data memories may have arbitrary wait states.
- Adds an illegal-instruction/misalignment trap, a retired-instruction counter and a selectable debug register read port.
- Sits at CPU top level; the memory subsystem (or a bench model) connects to the mem_* ports.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of mem_addr; the PC is 32 bits, and mem_addr carries the PC/address low ADDR_W bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- mem_req  out  1  memory access request; held high until accepted.
- mem_we  out  1  1 = store, 0 = load/fetch; valid while mem_req=1.
- mem_addr  out  ADDR_W  byte address, word-aligned.
- mem_wdata  out  32  store data; valid while mem_req=1 and mem_we=1.
- mem_ready  in  1  access accepted/completed in the cycle mem_req and mem_ready are both 1.
- mem_rdata  in  32  read data; valid when mem_req=1, mem_we=0 and mem_ready=1.
- dbg_sel  in  5  register index for the debug read.
- dbg_data  out  32  combinational read of register dbg_sel; reads 0 when dbg_sel=0.
- debug_pc  out  32  current PC.
- retired  out  32  instructions completed; wraps modulo 2^32.
- halted  out  1  1 after a trap.

Behaviour:
- Reset: pc=RESET_PC, state=FETCH, retired=0, halted=0, all 32 registers = 0. mem_req/mem_we are 0 in the cycle after a reset edge. Reset mid-access abandons the access with no register or memory side effects.
- ISA:
  - R-type (opcode 0), funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
  - addi 0x08 (sign-extended imm), andi 0x0C / ori 0x0D (zero-extended), lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
  - Arithmetic wraps; no overflow trap. $0 reads 0 and writes to it are discarded.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ready: IR <= mem_rdata, pc <= pc+4, go to DECODE.
  - Without mem_ready: hold, with outputs stable.
- DECODE: latch A=reg[rs], B=reg[rt]. Unsupported opcode or funct goes to TRAP. j: pc <= {pc[31:28], imm26, 2'b00}, retire, go to FETCH. Otherwise go to EXEC.
- EXEC:
  - ALU result latched.
  - beq/bne: if taken, pc <= pc + (sext(imm16)<<2), using the already-incremented pc. Retire, go to FETCH.
  - lw/sw: address = A + sext(imm). If addr[1:0] != 0, go to TRAP (no access); else go to MEM.
  - ALU ops: go to WB.
- MEM:
  - mem_req=1, mem_addr=address, mem_we=1 for sw with mem_wdata=B.
  - On mem_ready: sw retires and goes to FETCH; lw latches mem_rdata and goes to WB.
- WB: write rd (R-type) or rt (I-type/lw), retire, go to FETCH.
- Latencies with zero wait states (mem_ready tied high): j 2 cycles, beq/bne 3, R/I-ALU 4, sw 4, lw 5. Each wait cycle adds 1.
- retired increments by exactly 1 in the completing cycle of each instruction.
- TRAP:
  - halted=1, mem_req=0.
  - pc stays at faulting instruction address + 4; retired is not incremented.
  - Only reset exits TRAP.
- mem_ready while mem_req=0 is ignored.
- mem_addr, mem_we and mem_wdata do not change while mem_req=1 and mem_ready=0.

Test Plan:
- Reset with mem_ready=1 and program "addi $3,$0,5; addi $4,$0,7; add $3,$3,$4" -> after 12 cycles reg3=12 (dbg_sel=3), retired=3, debug_pc=12.
- Memory model with 3 wait cycles per access, program "addi $1,$0,0x40; sw $1,0($1); lw $2,0($1)" -> mem[0x40]=0x40, reg2=0x40. Address, we and data stay stable through the stalls. The lw takes 5+6=11 cycles.
- Loop "addi $1,$0,3; L: addi $1,$1,-1; bne $1,$0,L" -> loop body taken twice then falls through; reg1=0, retired=7.
- Opcode 0x3F at address 8 -> halted=1 after DECODE, mem_req stays 0, retired=2, debug_pc=12. Assert reset -> halted=0, pc=RESET_PC.
- lw with computed address 0x41 -> TRAP with no memory request issued; the destination register is unchanged.
- Assert reset while a MEM-state sw is stalled -> mem_req=0 next cycle, memory unchanged, next fetch at RESET_PC. "addi $0,$0,9" leaves dbg_data(0)=0.
